// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - command codes, pend bit indices and scheduler state encoding
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DROP   = 3'd4
  } cmd_e;

  localparam int PEND_LEFT  = 0;
  localparam int PEND_RIGHT = 1;
  localparam int PEND_ROT   = 2;
  localparam int PEND_DROP  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // Priority ROTATE > LEFT > RIGHT > DROP.
  function automatic cmd_e pick_cmd(input logic [3:0] m);
    if (m[PEND_ROT])        return CMD_ROTATE;
    else if (m[PEND_LEFT])  return CMD_LEFT;
    else if (m[PEND_RIGHT]) return CMD_RIGHT;
    else if (m[PEND_DROP])  return CMD_DROP;
    else                    return CMD_NONE;
  endfunction

  function automatic logic [3:0] cmd_bit(input cmd_e c);
    unique case (c)
      CMD_LEFT:   return 4'b0001;
      CMD_RIGHT:  return 4'b0010;
      CMD_ROTATE: return 4'b0100;
      CMD_DROP:   return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/tetris_step_sched_if.sv
// rtl/tetris_step_sched_if.sv - command handshake between scheduler and field engine
interface tetris_step_sched_if;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, cmd_code, output cmd_ready);
endinterface

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - 2-FF synchronizer with rising-edge pulses
module key_edge_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, prev;

  // prev starts at 0 so a key held across reset release yields one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
endmodule

// File: rtl/tetris_step_sched.sv
// rtl/tetris_step_sched.sv - frame-synchronous key/gravity command scheduler
// One command window per frame boundary; commands leave over a valid/ready handshake.
module tetris_step_sched
  import tetris_pkg::*;
#(
  parameter int DROP_FRAMES      = 30,
  parameter int SOFT_DROP_FRAMES = 2,
  parameter int CNT_W            = 6
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  input  logic                  draw_finish,
  input  logic [3:0]            op_keys,
  input  logic                  pause,
  tetris_step_sched_if.master   cmd,
  output logic                  frame_tick,
  output logic                  overrun
);
  logic [3:0] key_level, key_rise;
  logic       unused_keys;

  key_edge_sync #(.W(4)) u_key_edge_sync (
    .clk   (vga_clk),
    .rst_n (rst_n),
    .din   (op_keys),
    .level (key_level),
    .rise  (key_rise)
  );
  assign unused_keys = ^{key_level[2:0], key_rise[3]};

  logic df_q, boundary;
  assign boundary = draw_finish & ~df_q;

  logic [CNT_W-1:0] gcnt;
  logic [CNT_W:0]   gsum, period;
  logic             drop_fire;

  assign gsum      = {1'b0, gcnt} + (CNT_W+1)'(1);
  assign period    = key_level[PEND_DROP] ? (CNT_W+1)'(SOFT_DROP_FRAMES) : (CNT_W+1)'(DROP_FRAMES);
  assign drop_fire = boundary & ~pause & (gsum >= period);

  state_e     state, state_n;
  logic [3:0] pend, pend_n, mask, accept_bit;
  logic       valid_q, valid_n, accept;
  cmd_e       code_q, code_n;

  always_ff @(posedge vga_clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    valid_n = valid_q;
    code_n  = code_q;
    accept  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (boundary && !pause) state_n = ST_SCAN;
      end
      ST_SCAN: begin
        if (mask == '0) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_ISSUE;
          valid_n = 1'b1;
          code_n  = pick_cmd(mask);
        end
      end
      ST_ISSUE: begin
        if (cmd.cmd_ready) begin
          accept  = 1'b1;
          state_n = ST_SCAN;
          valid_n = 1'b0;
          code_n  = CMD_NONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Key edges are OR-ed after the acceptance clear: a same-cycle press is a new event.
  always_comb begin
    accept_bit = accept ? cmd_bit(code_q) : 4'b0000;
    pend_n     = pend & ~accept_bit;
    if (!pause) pend_n[2:0] = pend_n[2:0] | key_rise[2:0];
    if (drop_fire) pend_n[PEND_DROP] = 1'b1;
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      df_q       <= 1'b0;
      gcnt       <= '0;
      pend       <= '0;
      mask       <= '0;
      valid_q    <= 1'b0;
      code_q     <= CMD_NONE;
      frame_tick <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      df_q       <= draw_finish;
      frame_tick <= boundary;
      pend       <= pend_n;
      valid_q    <= valid_n;
      code_q     <= code_n;
      if (boundary && !pause) gcnt <= drop_fire ? '0 : gsum[CNT_W-1:0];
      if (state == ST_IDLE && state_n == ST_SCAN) mask <= pend_n;
      else                                        mask <= mask & ~accept_bit;
      if (boundary && state != ST_IDLE) overrun <= 1'b1;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_code  = code_q;
endmodule

// File: tb/tb_tetris_step_sched.sv
// tb/tb_tetris_step_sched.sv - directed self-checking bench for tetris_step_sched
module tb_tetris_step_sched;
  logic       vga_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       draw_finish = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] op_keys = 4'b0000;
  logic       frame_tick, overrun;

  tetris_step_sched_if bus ();

  tetris_step_sched dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .draw_finish (draw_finish),
    .op_keys     (op_keys),
    .pause       (pause),
    .cmd         (bus.master),
    .frame_tick  (frame_tick),
    .overrun     (overrun)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  int ticks = 0;
  int accepts = 0;
  int drop_at[$];
  logic [2:0] last_code = 3'd0;

  // Observer: counts frame ticks and accepted commands, remembers the frame of each DROP.
  always begin
    @(negedge vga_clk);
    #1;
    if (rst_n) begin
      if (frame_tick) ticks++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        accepts++;
        last_code = bus.cmd_code;
        if (bus.cmd_code == 3'd4) drop_at.push_back(ticks);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic frame(input int low);
    draw_finish = 1'b1;
    cyc(1);
    draw_finish = 1'b0;
    cyc(low);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_ready = 1'b0;
    cyc(3);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", bus.cmd_valid); end
    checks++; if (bus.cmd_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", bus.cmd_code); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0d expected 0", frame_tick); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", overrun); end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_gravity();
    int t0, a0, d0, got;
    bus.cmd_ready = 1'b1;
    t0 = ticks; a0 = accepts; d0 = drop_at.size();
    repeat (61) frame(99);
    checks++; if (ticks - t0 !== 61) begin errors++; $display("FAIL gravity_ticks: got %0d expected 61", ticks - t0); end
    checks++; if (accepts - a0 !== 2) begin errors++; $display("FAIL gravity_cmds: got %0d expected 2", accepts - a0); end
    checks++; if (drop_at.size() - d0 !== 2) begin errors++; $display("FAIL gravity_drops: got %0d expected 2", drop_at.size() - d0); end
    got = (drop_at.size() > d0) ? drop_at[d0] - t0 : -1;
    checks++; if (got !== 30) begin errors++; $display("FAIL gravity_frame1: got %0d expected 30", got); end
    got = (drop_at.size() > d0 + 1) ? drop_at[d0+1] - t0 : -1;
    checks++; if (got !== 60) begin errors++; $display("FAIL gravity_frame2: got %0d expected 60", got); end
  endtask

  task automatic test_key_order();
    logic       exp_v[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_c[7] = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0};
    bus.cmd_ready = 1'b1;
    op_keys = 4'b0111;
    cyc(5);
    op_keys = 4'b0000;
    cyc(2);
    draw_finish = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      draw_finish = 1'b0;
      checks++; if (bus.cmd_valid !== exp_v[i]) begin errors++; $display("FAIL order_valid[t+%0d]: got %0d expected %0d", i + 1, bus.cmd_valid, exp_v[i]); end
      checks++; if (bus.cmd_code !== exp_c[i]) begin errors++; $display("FAIL order_code[t+%0d]: got %0d expected %0d", i + 1, bus.cmd_code, exp_c[i]); end
      if (i < 2) begin
        checks++; if (frame_tick !== (i == 0)) begin errors++; $display("FAIL order_tick[t+%0d]: got %0d expected %0d", i + 1, frame_tick, (i == 0)); end
      end
    end
    cyc(3);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL order_idle: got %0d expected 0", bus.cmd_valid); end
  endtask

  task automatic test_backpressure();
    int a0;
    bus.cmd_ready = 1'b0;
    op_keys = 4'b0100;
    cyc(5);
    op_keys = 4'b0000;
    draw_finish = 1'b1;
    cyc(1);
    draw_finish = 1'b0;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd3) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%0d code=%0d expected valid=1 code=3", i, bus.cmd_valid, bus.cmd_code); end
      cyc(1);
    end
    a0 = accepts;
    bus.cmd_ready = 1'b1;
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd3) begin errors++; $display("FAIL bp_at_ready: got valid=%0d code=%0d expected valid=1 code=3", bus.cmd_valid, bus.cmd_code); end
    cyc(1);
    checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_code !== 3'd0) begin errors++; $display("FAIL bp_after: got valid=%0d code=%0d expected valid=0 code=0", bus.cmd_valid, bus.cmd_code); end
    cyc(2);
    checks++; if (accepts - a0 !== 1) begin errors++; $display("FAIL bp_accepts: got %0d expected 1", accepts - a0); end
  endtask

  task automatic test_overrun();
    int t0, a0, seen;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %0d expected 0", overrun); end
    bus.cmd_ready = 1'b0;
    op_keys = 4'b0001;
    cyc(5);
    op_keys = 4'b0000;
    frame(5);
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd1) begin errors++; $display("FAIL ovr_issue: got valid=%0d code=%0d expected valid=1 code=1", bus.cmd_valid, bus.cmd_code); end
    op_keys = 4'b0010;
    cyc(5);
    op_keys = 4'b0000;
    t0 = ticks;
    draw_finish = 1'b1;
    cyc(1);
    draw_finish = 1'b0;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL ovr_tick: got %0d expected 1", frame_tick); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0d expected 1", overrun); end
    checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd1) begin errors++; $display("FAIL ovr_held: got valid=%0d code=%0d expected valid=1 code=1", bus.cmd_valid, bus.cmd_code); end
    cyc(2);
    a0 = accepts;
    bus.cmd_ready = 1'b1;
    cyc(1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_valid) seen++;
      cyc(1);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL ovr_no_window: got %0d valid cycles expected 0", seen); end
    checks++; if (accepts - a0 !== 1) begin errors++; $display("FAIL ovr_accepts: got %0d expected 1", accepts - a0); end
    checks++; if (ticks - t0 !== 1) begin errors++; $display("FAIL ovr_ticks: got %0d expected 1", ticks - t0); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0d expected 1", overrun); end
    a0 = accepts;
    frame(10);
    checks++; if (accepts - a0 !== 1 || last_code !== 3'd2) begin errors++; $display("FAIL ovr_deferred: got %0d cmds last=%0d expected 1 cmds last=2", accepts - a0, last_code); end
  endtask

  task automatic test_softdrop_pause();
    int t0, a0, d0, got;
    int exp_rel[3] = '{1, 3, 5};
    op_keys = 4'b0000;
    pause = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sd_overrun_cleared: got %0d expected 0", overrun); end
    bus.cmd_ready = 1'b1;
    repeat (5) frame(20);
    op_keys = 4'b1000;
    cyc(3);
    t0 = ticks; a0 = accepts; d0 = drop_at.size();
    repeat (5) frame(20);
    checks++; if (accepts - a0 !== 3) begin errors++; $display("FAIL sd_cmds: got %0d expected 3", accepts - a0); end
    for (int k = 0; k < 3; k++) begin
      got = (drop_at.size() > d0 + k) ? drop_at[d0+k] - t0 : -1;
      checks++; if (got !== exp_rel[k]) begin errors++; $display("FAIL sd_frame[%0d]: got %0d expected %0d", k, got, exp_rel[k]); end
    end
    frame(20);
    checks++; if (accepts - a0 !== 3) begin errors++; $display("FAIL sd_odd_frame: got %0d expected 3", accepts - a0); end
    pause = 1'b1;
    op_keys = 4'b1100;
    cyc(5);
    t0 = ticks; a0 = accepts;
    repeat (3) frame(20);
    checks++; if (ticks - t0 !== 3) begin errors++; $display("FAIL pause_ticks: got %0d expected 3", ticks - t0); end
    checks++; if (accepts - a0 !== 0) begin errors++; $display("FAIL pause_cmds: got %0d expected 0", accepts - a0); end
    pause = 1'b0;
    op_keys = 4'b1000;
    cyc(3);
    a0 = accepts;
    frame(20);
    checks++; if (accepts - a0 !== 1 || last_code !== 3'd4) begin errors++; $display("FAIL pause_frozen: got %0d cmds last=%0d expected 1 cmds last=4", accepts - a0, last_code); end
    a0 = accepts;
    frame(20);
    checks++; if (accepts - a0 !== 0) begin errors++; $display("FAIL pause_rot_ignored: got %0d expected 0", accepts - a0); end
    op_keys = 4'b0000;
    cyc(3);
  endtask

  task automatic test_reset_mid_issue();
    int n, a0;
    bus.cmd_ready = 1'b0;
    op_keys = 4'b0010;
    cyc(5);
    op_keys = 4'b0000;
    draw_finish = 1'b1;
    cyc(1);
    draw_finish = 1'b0;
    n = 0;
    while (!bus.cmd_valid && n < 10) begin
      cyc(1);
      n++;
    end
    checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL rmi_wait_valid: got %0d expected 1", bus.cmd_valid); end
    rst_n = 1'b0;
    cyc(1);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rmi_valid: got %0d expected 0", bus.cmd_valid); end
    checks++; if (bus.cmd_code !== 3'd0) begin errors++; $display("FAIL rmi_code: got %0d expected 0", bus.cmd_code); end
    checks++; if (frame_tick !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmi_flags: got tick=%0d overrun=%0d expected 0 0", frame_tick, overrun); end
    rst_n = 1'b1;
    bus.cmd_ready = 1'b1;
    cyc(2);
    a0 = accepts;
    frame(20);
    checks++; if (accepts - a0 !== 0) begin errors++; $display("FAIL rmi_pend_cleared: got %0d expected 0", accepts - a0); end
  endtask

  initial begin
    bus.cmd_ready = 1'b0;
    cyc(1);
    test_reset();
    test_gravity();
    test_key_order();
    test_backpressure();
    test_overrun();
    test_softdrop_pause();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tetris_step_sched.md
# tetris_step_sched

Frame-synchronous command scheduler for the Tetris field logic, clocked on `vga_clk`. It turns raw `op_keys` presses and a frame-counted gravity timer into a serialized stream of game commands. One command window opens per VGA frame, at the `draw_finish` boundary. Commands go to the field/piece engine over a valid/ready handshake, so the field is only mutated between screen draws.

## Interface
Parameters:
- `DROP_FRAMES`, 30: frames per gravity step in normal play (0.5 s at 60 Hz).
- `SOFT_DROP_FRAMES`, 2: frames per gravity step while soft-drop is held.
- `CNT_W`, 6: gravity counter width; must hold `DROP_FRAMES-1`.

Ports:
- `vga_clk`, in, 1: sole clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `draw_finish`, in, 1: same-domain level from the VGA timing block. Its rising edge marks a frame boundary.
- `op_keys`, in, 4: debounced, asynchronous, active-high keys. [0] left, [1] right, [2] rotate, [3] soft-drop.
- `pause`, in, 1: freezes gravity, key capture and new windows.
- `cmd_ready`, in, 1: the field engine accepts `cmd_code`.
- `cmd_valid`, out, 1: a command is offered.
- `cmd_code`, out, 3: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DROP. Reads 0 when idle.
- `frame_tick`, out, 1: one-cycle pulse per frame boundary.
- `overrun`, out, 1: sticky; a frame boundary arrived while a window was still open.

## Operation
- Key path:
  - `op_keys` passes through a 2-FF synchronizer, then a rising-edge detector.
  - A rising edge on bits [2:0] sets `pend[ROT/LEFT/RIGHT]`.
  - Bit [3] is used as a synced level only.
  - Edges are ignored while `pause`=1. Existing pend bits are kept.
- Gravity: `gcnt` counts frame boundaries, but only when `pause`=0.
  - Period `P` = `SOFT_DROP_FRAMES` if synced key[3]=1, else `DROP_FRAMES`.
  - On a boundary with `gcnt+1 >= P`: set `pend[DROP]` and set `gcnt` to 0.
  - On any other boundary: `gcnt` increments by 1.
  - If soft-drop is pressed while `gcnt >= SOFT_DROP_FRAMES-1`, DROP fires on the next boundary.
- Frame boundary: `draw_finish`=1 and its previous-cycle value was 0.
  - `frame_tick` pulses on every boundary.
  - `gcnt` advances on every boundary, independent of FSM state.
- FSM states: IDLE, SCAN, ISSUE.
  - IDLE → SCAN on a boundary with `pause`=0. At that edge `mask` ← `pend`, including a DROP set on the same edge.
  - SCAN: picks the highest-priority bit set in `mask`. Priority is ROTATE > LEFT > RIGHT > DROP. If no bit is set, go to IDLE. Otherwise go to ISSUE, load `cmd_code` and raise `cmd_valid`.
  - ISSUE: hold `cmd_valid` and `cmd_code` until `cmd_ready`=1.
  - On acceptance: clear that bit in both `mask` and `pend`, then go to SCAN.
- Each window issues each command at most once. Events arriving after the snapshot wait for the next window.
- If a key edge and acceptance of the same command land in the same cycle, `pend` stays set (it is a new event).
- LEFT and RIGHT both pending: both are issued, LEFT first.
- A boundary arriving while in SCAN or ISSUE:
  - `overrun` ← 1.
  - `frame_tick` and gravity proceed normally.
  - The current window continues and no new window is queued.
  - `cmd_valid` is never withdrawn before acceptance.
- `pause` rising mid-window: the window completes and no new window opens.

## Timing
- Values on reset (`rst_n`=0 at an edge): state IDLE; `pend`, `mask`, `gcnt`, synchronizers and edge registers all 0; `cmd_valid`=0, `cmd_code`=0, `frame_tick`=0, `overrun`=0.
- Reset wins over every other event in the same cycle, including mid-handshake. The field engine must treat reset as a discard of the offered command.
- A key held, or `draw_finish` high, across reset release yields one event, because the edge registers start at 0.
- `draw_finish` rising in cycle t:
  - `frame_tick`=1 in cycle t+1 only.
  - State SCAN in t+1.
  - First `cmd_valid` in t+2.
- Each accepted command costs 2 cycles (ISSUE→SCAN→ISSUE) when `cmd_ready` is held high.
- Key rising in cycle k sets `pend` visible in k+3.

## Structure
- A shared `tetris_pkg` holds the `cmd_code` encodings, the pend bit indices and the FSM state encoding.
- One sub-module, `key_edge_sync`: 4-bit 2-FF synchronizer with rising-edge pulses, reset to 0.

## Test plan
- **Gravity cadence.** No keys, `draw_finish` pulsed every 100 cycles for 61 frames → exactly 2 DROP commands, on frames 30 and 60; `frame_tick` count = 61.
- **Key ordering.** Left, right and rotate pressed between boundaries, `cmd_ready`=1 → codes 3, 1, 2 in consecutive 2-cycle steps starting at t+2, then IDLE.
- **Backpressure.** `cmd_ready`=0 for 10 cycles during ISSUE → `cmd_valid` and `cmd_code` stable throughout; command accepted on the cycle `cmd_ready` rises.
- **Overrun.** Hold `cmd_ready`=0 across the next boundary → `overrun`=1 (stays 1), `frame_tick` pulses, no second window, `gcnt` advanced.
- **Soft drop and pause.** Hold key[3] with `gcnt`=5 → DROP on the next boundary and then every 2 frames. Assert `pause` → `gcnt` frozen, rotate press ignored, no windows.
- **Reset mid-ISSUE.** `rst_n`=0 with `cmd_valid`=1 → next cycle all outputs 0, `pend` cleared.
